// File: rtl/reg_grp_demux.sv
// Register-bus fan-out: forwards one level-held request to the slave picked by the
// upper address bits and returns its ack/data, with a watchdog forcing completion.
module reg_grp_demux #(
   parameter int ADDR_WIDTH = 12,
   parameter int SEL_WIDTH = 2,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT = 64,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_DEAD,
   localparam int NUM_OUTPUTS = 2**SEL_WIDTH
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              reg_req,
   output logic                              reg_ack,
   input  logic                              reg_rd_wr_L,
   input  logic [ADDR_WIDTH-1:0]             reg_addr,
   input  logic [DATA_WIDTH-1:0]             reg_wr_data,
   output logic [DATA_WIDTH-1:0]             reg_rd_data,
   output logic [NUM_OUTPUTS-1:0]            local_reg_req,
   input  logic [NUM_OUTPUTS-1:0]            local_reg_ack,
   output logic                              local_reg_rd_wr_L,
   output logic [ADDR_WIDTH-SEL_WIDTH-1:0]   local_reg_addr,
   output logic [DATA_WIDTH-1:0]             local_reg_wr_data,
   input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] local_reg_rd_data
);

   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_HOLD} state_t;

   state_t                          r_state;
   logic [SEL_WIDTH-1:0]            r_sel;
   logic [15:0]                     r_cnt;
   logic                            r_ack;
   logic [DATA_WIDTH-1:0]           r_rd_data;
   logic [NUM_OUTPUTS-1:0]          r_req;
   logic                            r_rd_wr_L;
   logic [ADDR_WIDTH-SEL_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]           r_wr_data;

   logic [DATA_WIDTH-1:0]           w_slave_data [NUM_OUTPUTS];
   logic [SEL_WIDTH-1:0]            w_sel_in;
   logic [NUM_OUTPUTS-1:0]          w_onehot;
   logic                            w_sel_ack;
   logic                            w_timeout;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_unpack
         assign w_slave_data[gi] = local_reg_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign w_sel_in  = reg_addr[ADDR_WIDTH-1 -: SEL_WIDTH];
   assign w_onehot  = NUM_OUTPUTS'(1) << w_sel_in;
   // Only the selected slave's ack matters; others may be stuck or noisy.
   assign w_sel_ack = local_reg_ack[r_sel];
   assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_cnt     <= '0;
         r_ack     <= 1'b0;
         r_rd_data <= '0;
         r_req     <= '0;
         r_rd_wr_L <= 1'b1;
         r_addr    <= '0;
         r_wr_data <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (reg_req) begin
                  r_sel     <= w_sel_in;
                  r_addr    <= reg_addr[ADDR_WIDTH-SEL_WIDTH-1:0];
                  r_rd_wr_L <= reg_rd_wr_L;
                  r_wr_data <= reg_wr_data;
                  r_req     <= w_onehot;
                  r_cnt     <= '0;
                  r_state   <= ST_FWD;
               end
            end
            ST_FWD: begin
               if (r_cnt != 16'hFFFF) begin
                  r_cnt <= r_cnt + 16'd1;
               end
               // A slave ack arriving on the watchdog's last cycle still wins.
               if (w_sel_ack) begin
                  r_req     <= '0;
                  r_rd_data <= w_slave_data[r_sel];
                  r_ack     <= 1'b1;
                  r_state   <= ST_HOLD;
               end else if (w_timeout) begin
                  r_req     <= '0;
                  r_rd_data <= TIMEOUT_DATA;
                  r_ack     <= 1'b1;
                  r_state   <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!reg_req) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign reg_ack           = r_ack;
   assign reg_rd_data       = r_rd_data;
   assign local_reg_req     = r_req;
   assign local_reg_rd_wr_L = r_rd_wr_L;
   assign local_reg_addr    = r_addr;
   assign local_reg_wr_data = r_wr_data;

endmodule
